// File: rtl/retire_trace_if.sv
// Retire-trace bus: the write-back capture port and the trace consumer port.
// The slave modport is the trace unit; the master modport is its environment.
interface retire_trace_if;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i;
    logic [31:0] wb_insn_i;
    logic        wb_we_i;
    logic [4:0]  wb_dst_i;
    logic [31:0] wb_r_i;
    logic        trc_ready_i;
    logic        trc_valid_o;
    logic [31:0] trc_order_o;
    logic [31:0] trc_pc_o;
    logic [31:0] trc_insn_o;
    logic        trc_we_o;
    logic [4:0]  trc_dst_o;
    logic [31:0] trc_r_o;

    // Handshake: the head entry transfers on every rising edge where
    // trc_valid_o && trc_ready_i; while valid and not ready the trc_* outputs hold.
    modport slave (
        input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, trc_ready_i,
        output trc_valid_o, trc_order_o, trc_pc_o, trc_insn_o, trc_we_o, trc_dst_o, trc_r_o
    );
    modport master (
        output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, trc_ready_i,
        input  trc_valid_o, trc_order_o, trc_pc_o, trc_insn_o, trc_we_o, trc_dst_o, trc_r_o
    );
endinterface

// File: rtl/retire_trace.sv
// Retire trace FIFO: captures every retiring instruction with a sequence number, drops on full.
// Optional macro RETIRE_TRACE_X0_MASK_EN: writes to x0 are recorded as we=0, r=0.
module retire_trace #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    retire_trace_if.slave            bus,
    input  logic                     clr_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [31:0]       order_q, order_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic   full, push, pop, drop;
    entry_t wr_entry, head;

    assign full = (count_q == (AW+1)'(DEPTH));
    assign pop  = (count_q != '0) && bus.trc_ready_i;
    // A full FIFO still accepts a retire when the head leaves in the same cycle.
    assign push = bus.wb_valid_i && (!full || pop);
    assign drop = bus.wb_valid_i && full && !pop;

    always_comb begin
        wr_entry.order = order_q;
        wr_entry.pc    = bus.wb_pc_i;
        wr_entry.insn  = bus.wb_insn_i;
        wr_entry.dst   = bus.wb_dst_i;
`ifdef RETIRE_TRACE_X0_MASK_EN
        wr_entry.we    = bus.wb_we_i && (bus.wb_dst_i != 5'd0);
        wr_entry.r     = (bus.wb_dst_i == 5'd0) ? 32'd0 : bus.wb_r_i;
`else
        wr_entry.we    = bus.wb_we_i;
        wr_entry.r     = bus.wb_r_i;
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        order_d    = order_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + (AW+1)'(1);
        if (pop && !push) count_d = count_q - (AW+1)'(1);
        if (bus.wb_valid_i) order_d = order_q + 32'd1;
        // A drop in the clearing cycle is the first event of the new window.
        if (clr_i) begin
            overflow_d = drop;
            drop_d     = drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_q)) drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    // Outputs read zero while empty, which also gives the reset values.
    assign head            = mem_q[rd_ptr_q];
    assign bus.trc_valid_o = (count_q != '0);
    assign bus.trc_order_o = bus.trc_valid_o ? head.order : 32'd0;
    assign bus.trc_pc_o    = bus.trc_valid_o ? head.pc    : 32'd0;
    assign bus.trc_insn_o  = bus.trc_valid_o ? head.insn  : 32'd0;
    assign bus.trc_we_o    = bus.trc_valid_o && head.we;
    assign bus.trc_dst_o   = bus.trc_valid_o ? head.dst   : 5'd0;
    assign bus.trc_r_o     = bus.trc_valid_o ? head.r     : 32'd0;

    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_retire_trace.sv
// Bench for retire_trace: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_retire_trace;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_i = 1'b0;
  logic [CW-1:0]     count_o;
  logic              overflow_o;
  logic [DROP_W-1:0] drop_cnt_o;

  retire_trace_if tb_if ();

  retire_trace #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (tb_if),
    .clr_i      (clr_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] r;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_order;
  logic        m_ovf;
  int unsigned m_drop;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          chk_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, drops and counters follow the rules directly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_order = 32'd0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      bit   popped, pushed, dropped;
      ent_t e;
      popped  = (exp_q.size() != 0) && tb_if.trc_ready_i;
      pushed  = tb_if.wb_valid_i && ((exp_q.size() < DEPTH) || popped);
      dropped = tb_if.wb_valid_i && !pushed;
      e.order = m_order;
      e.pc    = tb_if.wb_pc_i;
      e.insn  = tb_if.wb_insn_i;
      e.we    = tb_if.wb_we_i;
      e.dst   = tb_if.wb_dst_i;
      e.r     = tb_if.wb_r_i;
`ifdef RETIRE_TRACE_X0_MASK_EN
      if (e.dst == 5'd0) begin
        e.we = 1'b0;
        e.r  = 32'd0;
      end
`endif
      if (popped) void'(exp_q.pop_front());
      if (pushed) exp_q.push_back(e);
      if (tb_if.wb_valid_i) m_order = m_order + 32'd1;
      if (clr_i) begin
        m_ovf  = dropped;
        m_drop = dropped ? 1 : 0;
      end else if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < (2**DROP_W - 1)) m_drop++;
      end
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("count", count_o, exp_q.size());
      check("overflow", overflow_o, m_ovf);
      check("drop_cnt", drop_cnt_o, m_drop);
      check("valid", tb_if.trc_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("order", tb_if.trc_order_o, exp_q[0].order);
        check("pc", tb_if.trc_pc_o, exp_q[0].pc);
        check("insn", tb_if.trc_insn_o, exp_q[0].insn);
        check("we", tb_if.trc_we_o, exp_q[0].we);
        check("dst", tb_if.trc_dst_o, exp_q[0].dst);
        check("r", tb_if.trc_r_o, exp_q[0].r);
      end else begin
        check("idle_fields", {tb_if.trc_order_o, tb_if.trc_pc_o}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    tb_if.wb_valid_i = 1'b0;
    tb_if.wb_pc_i    = $urandom;
    tb_if.wb_insn_i  = $urandom;
    tb_if.wb_we_i    = 1'($urandom_range(0, 1));
    tb_if.wb_dst_i   = 5'($urandom_range(0, 31));
    tb_if.wb_r_i     = $urandom;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                        input logic we, input logic [4:0] dst, input logic [31:0] r);
    tb_if.wb_valid_i = 1'b1;
    tb_if.wb_pc_i    = pc;
    tb_if.wb_insn_i  = insn;
    tb_if.wb_we_i    = we;
    tb_if.wb_dst_i   = dst;
    tb_if.wb_r_i     = r;
  endtask

  task automatic retire_rand();
    retire($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_i = 1'b0;
    tb_if.trc_ready_i = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tb_if.trc_ready_i = 1'b0;
    idle();
    do_reset();

    // Reset state
    check("rst_valid", tb_if.trc_valid_o, 1'b0);
    check("rst_count", count_o, 0);
    check("rst_fields", {tb_if.trc_we_o, tb_if.trc_dst_o, tb_if.trc_r_o, tb_if.trc_insn_o}, 64'd0);

    // Single retire, one-cycle visibility, then drained
    retire(32'h200, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
    tb_if.trc_ready_i = 1'b1;
    @(negedge clk);
    check("r37_valid", tb_if.trc_valid_o, 1'b1);
    check("r37_order", tb_if.trc_order_o, 32'd0);
    check("r37_pc", tb_if.trc_pc_o, 32'h200);
    idle();
    @(negedge clk);
    check("r37_count", count_o, 0);

    // Nine retires into an eight-deep FIFO with the consumer stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      retire_rand();
      @(negedge clk);
    end
    idle();
    check("r38_count", count_o, 8);
    check("r38_ovf", overflow_o, 1'b1);
    check("r38_drop", drop_cnt_o, 1);
    tb_if.trc_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("r38_drain_order", tb_if.trc_order_o, k);
      @(negedge clk);
    end
    check("r38_empty", count_o, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      retire_rand();
      @(negedge clk);
    end
    retire_rand();
    tb_if.trc_ready_i = 1'b1;
    @(negedge clk);
    idle();
    check("r39_count", count_o, 8);
    check("r39_drop", drop_cnt_o, 0);
    for (int k = 0; k < 8; k++) begin
      check("r39_order", tb_if.trc_order_o, k + 1);
      @(negedge clk);
    end

    // Stalled consumer holds the head stable
    do_reset();
    retire(32'h1000, 32'h00f2_f293, 1'b1, 5'd5, 32'h0F);
    @(negedge clk);
    idle();
    for (int c = 0; c < 3; c++) begin
      check("r40_r", tb_if.trc_r_o, 32'h0F);
      check("r40_dst_we", {tb_if.trc_dst_o, tb_if.trc_we_o}, {5'd5, 1'b1});
      check("r40_pc", tb_if.trc_pc_o, 32'h1000);
      @(negedge clk);
    end
    tb_if.trc_ready_i = 1'b1;
    @(negedge clk);
    check("r40_once", count_o, 0);

    // Write to x0
    do_reset();
    retire(32'h300, 32'h0000_0000, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    idle();
`ifdef RETIRE_TRACE_X0_MASK_EN
    check("r41_we", tb_if.trc_we_o, 1'b0);
    check("r41_r", tb_if.trc_r_o, 32'd0);
`else
    check("r41_we", tb_if.trc_we_o, 1'b1);
    check("r41_r", tb_if.trc_r_o, 32'h1234);
`endif

    // Drop counter saturation, then clear with and without a same-cycle drop
    do_reset();
    for (int i = 0; i < 28; i++) begin
      retire_rand();
      @(negedge clk);
    end
    check("sat_drop", drop_cnt_o, 2**DROP_W - 1);
    clr_i = 1'b1;
    @(negedge clk);
    idle();
    check("clr_drop_ovf", overflow_o, 1'b1);
    check("clr_drop_cnt", drop_cnt_o, 1);
    check("clr_keeps_fifo", count_o, 8);
    @(negedge clk);
    clr_i = 1'b0;
    check("clr_ovf", overflow_o, 1'b0);
    check("clr_cnt", drop_cnt_o, 0);

    // Asynchronous reset mid-cycle with entries queued
    do_reset();
    for (int i = 0; i < 9; i++) begin
      retire_rand();
      @(negedge clk);
    end
    idle();
    tb_if.trc_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    tb_if.trc_ready_i = 1'b0;
    check("r42_pre_count", count_o, 5);
    check("r42_pre_ovf", overflow_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r42_count", count_o, 0);
    check("r42_ovf", overflow_o, 1'b0);
    check("r42_valid", tb_if.trc_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    retire_rand();
    @(negedge clk);
    idle();
    check("r42_order", tb_if.trc_order_o, 32'd0);
    check("r42_valid2", tb_if.trc_valid_o, 1'b1);

    // Randomized traffic in blocks with varying valid/ready pressure
    for (int b = 0; b < 20; b++) begin
      int unsigned p_valid, p_ready;
      p_valid = $urandom_range(20, 100);
      p_ready = $urandom_range(0, 100);
      if (b == 10) do_reset();
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) < p_valid) retire_rand();
        else idle();
        tb_if.trc_ready_i = ($urandom_range(0, 99) < p_ready);
        clr_i = ($urandom_range(0, 31) == 0);
        @(negedge clk);
      end
    end
    idle();
    clr_i = 1'b0;
    tb_if.trc_ready_i = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_trace.md
RETIRE_TRACE -- requirements
Module: retire_trace

Interface
REQ-001 Parameter: DEPTH, 8, trace FIFO entries; power of two, 2..64.
REQ-002 Parameter: DROP_W, 16, width of dropped-retire counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wb_valid_i  input  1  non-bubble instruction retiring from WB this cycle.
REQ-006 wb_pc_i  input  32  PC of retiring instruction.
REQ-007 wb_insn_i  input  32  instruction word of retiring instruction.
REQ-008 wb_we_i  input  1  register-file write enable from WB.
REQ-009 wb_dst_i  input  5  destination register index from WB.
REQ-010 wb_r_i  input  32  write-back value from WB.
REQ-011 clr_i  input  1  synchronous clear of overflow flag and drop counter.
REQ-012 trc_ready_i  input  1  consumer accepts head entry.
REQ-013 trc_valid_o  output  1  head entry present.
REQ-014 trc_order_o  output  32  retire sequence number of head entry.
REQ-015 trc_pc_o / trc_insn_o / trc_r_o  output  32 each  captured PC, instruction, write-back value.
REQ-016 trc_we_o  output  1, trc_dst_o  output  5  captured write enable and destination.
REQ-017 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 overflow_o  output  1  sticky: at least one retire was dropped.
REQ-019 drop_cnt_o  output  DROP_W  number of dropped retires, saturating.

Function
REQ-020 Push occurs when wb_valid_i=1 and (FIFO not full, or pop in same cycle); entry = {order, pc, insn, we, dst, r} sampled that edge.
REQ-021 Pop occurs when trc_valid_o=1 and trc_ready_i=1.
REQ-022 Order counter increments by 1 on every wb_valid_i=1 cycle, accepted or dropped, wrapping 0xFFFFFFFF->0; order gaps expose drops.
REQ-023 First-word-fall-through: entry pushed at edge N is visible on trc_* outputs after edge N when FIFO was empty (one-cycle latency).
REQ-024 trc_valid_o = (count_o != 0); trc_* outputs are held stable while trc_valid_o=1 and trc_ready_i=0.
REQ-025 Full (count_o=DEPTH) with wb_valid_i=1 and no pop: entry discarded, overflow_o set, drop_cnt_o incremented, FIFO contents unchanged.
REQ-026 Full with simultaneous push and pop: both occur, count_o stays DEPTH, no drop.
REQ-027 Empty with trc_ready_i=1: no pop, count_o stays 0.
REQ-028 drop_cnt_o saturates at 2^DROP_W-1.
REQ-029 clr_i=1 clears overflow_o and drop_cnt_o at next edge; FIFO and order counter unaffected; clr_i with a drop in the same cycle leaves overflow_o=1, drop_cnt_o=1.
REQ-030 Read/write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
REQ-031 Inputs other than wb_valid_i are ignored when wb_valid_i=0.

Reset
REQ-032 rst_n low immediately clears count_o, pointers, order counter, overflow_o, drop_cnt_o; trc_valid_o=0.
REQ-033 Reset during operation discards all queued entries; first retire after release has order 0.
REQ-034 trc_pc_o, trc_insn_o, trc_r_o, trc_order_o reset to 0; trc_we_o=0; trc_dst_o=0.

Configuration
REQ-035 Macro RETIRE_TRACE_X0_MASK_EN defined: entries with wb_dst_i=0 store we=0 and r=0 regardless of wb_we_i/wb_r_i.
REQ-036 Macro undefined: wb_we_i and wb_r_i stored unmodified for all destinations.

Verification
REQ-037 Reset, then retire pc=0x200 insn=0x00000013 dst=0; trc_ready_i=1 -> one cycle later trc_valid_o=1, order=0, pc=0x200, then count_o returns 0.
REQ-038 trc_ready_i=0, retire 9 consecutive instructions with DEPTH=8 -> count_o=8, overflow_o=1, drop_cnt_o=1, head order=0; drain gives orders 0..7.
REQ-039 Full FIFO, wb_valid_i=1 and trc_ready_i=1 same cycle -> count_o=8, drop_cnt_o unchanged, new tail order=8.
REQ-040 Retire andi x5 (dst=5, we=1, r=0x0F) with consumer stalled 3 cycles -> trc_* stable all 3 cycles, value 0x0F delivered once.
REQ-041 Retire dst=0, we=1, r=0x1234 -> with RETIRE_TRACE_X0_MASK_EN trc_we_o=0, trc_r_o=0; without it trc_we_o=1, trc_r_o=0x1234.
REQ-042 Assert rst_n low with count_o=5, overflow_o=1 -> count_o=0, overflow_o=0, trc_valid_o=0 immediately; next retire has order 0.
